// File: rtl/seq_pkg.sv
// Shared mode encodings and default parameter values for the step sequencer.
package seq_pkg;

   localparam int unsigned DefLanes   = 16;
   localparam int unsigned DefSteps   = 40;
   localparam int unsigned DefTickDiv = 11026;

   // Encoding 2'd3 is never entered; the FSM maps it back to StPlaying.
   typedef enum logic [1:0] {
      StPlaying   = 2'd0,
      StRecording = 2'd1,
      StOverdub   = 2'd2
   } mode_e;

   // Mode cycle taken on each rising edge of the mode request.
   function automatic mode_e next_mode(input mode_e cur);
      case (cur)
         StPlaying:   next_mode = StRecording;
         StRecording: next_mode = StOverdub;
         default:     next_mode = StPlaying;
      endcase
   endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control and playback signals between the step sequencer and its user.
interface step_sequencer_if
   import seq_pkg::*;
#(
   parameter int unsigned LANES = DefLanes,
   parameter int unsigned STEPS = DefSteps
) ();

   logic                       mode;
   logic                       playEn;
   logic [$clog2(STEPS+1)-1:0] loop_len;
   logic [LANES-1:0]           data;
   logic [LANES-1:0]           seqOut;
   logic [$clog2(STEPS)-1:0]   step_idx;
   logic                       step_pulse;
   logic [1:0]                 state;

   // User side: drives requests and pad hits, observes playback.
   modport master (
      output mode, playEn, loop_len, data,
      input  seqOut, step_idx, step_pulse, state
   );

   // Sequencer side.
   modport slave (
      input  mode, playEn, loop_len, data,
      output seqOut, step_idx, step_pulse, state
   );

endinterface

// File: rtl/step_timer.sv
// Step tick divider: one-cycle tick every TICK_DIV clock cycles.
module step_timer
   import seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = DefTickDiv
) (
   input  logic clock,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] Reload = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q, count_d;

   // Tick fires while the counter sits at zero; the reload happens in the same cycle.
   assign tick = (count_q == '0);

   // Down-count, reloading on tick so the period is exactly TICK_DIV cycles.
   always_comb begin
      count_d = count_q - CW'(1);
      if (tick) begin
         count_d = Reload;
      end
   end

   // Counter register; clear restarts a full step period.
   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= Reload;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/step_sequencer.sv
// Pad step sequencer: records lane hits into a step pattern and plays them back.
module step_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned LANES    = DefLanes,
   parameter int unsigned STEPS    = DefSteps,
   parameter int unsigned TICK_DIV = DefTickDiv
) (
   input  logic           clock,
   input  logic           clear,
   step_sequencer_if.slave bus
);

   localparam int unsigned PW = $clog2(STEPS);
   localparam int unsigned LW = $clog2(STEPS + 1);

   mode_e            state_q, state_d;
   logic             mode_prev_q;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [LANES-1:0] hold_q, hold_d;
   logic [LANES-1:0] seq_out_q, seq_out_d;
   logic             step_pulse_q;
   logic [LANES-1:0] mem_q [STEPS];

   logic             tick;
   logic             mode_rise;
   logic             capture;
   logic             play_out;
   logic             step_en;
   logic [LW-1:0]    eff_len;
   logic             wrap;
   logic             mem_we;
   logic [LANES-1:0] mem_rd;
   logic [LANES-1:0] mem_wdata;

   step_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_timer (
      .clock(clock),
      .clear(clear),
      .tick (tick)
   );

   assign mode_rise = bus.mode & ~mode_prev_q;

   // Mode FSM next state plus per-mode datapath enables (tick uses the old mode).
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      play_out = 1'b0;
      step_en  = 1'b0;
      if (mode_rise) begin
         state_d = next_mode(state_q);
      end
      case (state_q)
         StPlaying: begin
            play_out = bus.playEn;
            step_en  = bus.playEn;
         end
         StRecording: begin
            capture = 1'b1;
            step_en = 1'b1;
         end
         StOverdub: begin
            capture  = 1'b1;
            play_out = 1'b1;
            step_en  = 1'b1;
         end
         default: begin
            state_d = StPlaying;
         end
      endcase
   end

   // Loop length, pointer advance, hold accumulation and playback strobe.
   always_comb begin
      eff_len = LW'(STEPS);
      if (bus.loop_len != '0 && bus.loop_len <= LW'(STEPS)) begin
         eff_len = bus.loop_len;
      end
      // Compare with >= so a loop shortened below the pointer still wraps.
      wrap = (LW'(ptr_q) >= (eff_len - LW'(1)));

      ptr_d = ptr_q;
      if (tick && step_en) begin
         ptr_d = wrap ? '0 : ptr_q + PW'(1);
      end

      hold_d = hold_q;
      if (tick || mode_rise) begin
         hold_d = '0;
      end else if (capture) begin
         hold_d = hold_q | bus.data;
      end

      mem_rd    = mem_q[ptr_q];
      seq_out_d = (tick && play_out) ? mem_rd : '0;

      // Include this cycle's hits so a hit landing on the tick is not lost.
      mem_we    = tick & capture;
      mem_wdata = hold_q | bus.data;
      if (state_q == StOverdub) begin
         mem_wdata = mem_wdata | mem_rd;
      end
   end

   // Control and output registers; clear wins over every other input.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q      <= StPlaying;
         mode_prev_q  <= 1'b0;
         ptr_q        <= '0;
         hold_q       <= '0;
         seq_out_q    <= '0;
         step_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_prev_q  <= bus.mode;
         ptr_q        <= ptr_d;
         hold_q       <= hold_d;
         seq_out_q    <= seq_out_d;
         step_pulse_q <= tick;
      end
   end

   // Pattern memory with a single write port, zeroed while clear is held.
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int unsigned i = 0; i < STEPS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[ptr_q] <= mem_wdata;
      end
   end

   assign bus.seqOut     = seq_out_q;
   assign bus.step_idx   = ptr_q;
   assign bus.step_pulse = step_pulse_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized self-checking bench for step_sequencer against a step-level model.
module tb_step_sequencer;

   localparam int LANES    = 4;
   localparam int STEPS    = 8;
   localparam int TICK_DIV = 4;

   logic clock;
   logic clear;

   step_sequencer_if #(.LANES(LANES), .STEPS(STEPS)) bus ();

   step_sequencer #(
      .LANES   (LANES),
      .STEPS   (STEPS),
      .TICK_DIV(TICK_DIV)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int vectors;
   int miscompares;

   // Reference model: phase = cycles since release modulo TICK_DIV.
   int         m_state;
   int         m_phase;
   int         m_ptr;
   bit         m_mode_prev;
   logic [3:0] m_hold;
   logic [3:0] m_seq;
   logic       m_pulse;
   logic [3:0] m_mem [STEPS];

   task automatic model_step(input logic c, input logic m, input logic p,
                             input logic [3:0] len, input logic [3:0] d);
      bit tick;
      bit rise;
      int eff;
      if (c) begin
         m_state = 0; m_phase = 0; m_ptr = 0; m_mode_prev = 0;
         m_hold = 0; m_seq = 0; m_pulse = 0;
         for (int i = 0; i < STEPS; i++) m_mem[i] = 4'b0;
         return;
      end
      tick    = (m_phase == TICK_DIV - 1);
      m_phase = (m_phase + 1) % TICK_DIV;
      rise    = m && !m_mode_prev;
      eff     = (len >= 1 && int'(len) <= STEPS) ? int'(len) : STEPS;
      m_pulse = tick;
      m_seq   = (tick && ((m_state == 0 && p) || m_state == 2)) ? m_mem[m_ptr] : 4'b0;
      if (tick) begin
         if (m_state == 1) m_mem[m_ptr] = m_hold | d;
         else if (m_state == 2) m_mem[m_ptr] = m_mem[m_ptr] | m_hold | d;
         if (m_state != 0 || p) m_ptr = (m_ptr >= eff - 1) ? 0 : m_ptr + 1;
      end
      if (tick || rise) m_hold = 4'b0;
      else if (m_state != 0) m_hold = m_hold | d;
      if (rise) m_state = (m_state + 1) % 3;
      m_mode_prev = m;
   endtask

   function automatic logic [9:0] exp_vec();
      return {2'(m_state), 3'(m_ptr), m_pulse, m_seq};
   endfunction

   function automatic logic [9:0] obs();
      return {bus.state, bus.step_idx, bus.step_pulse, bus.seqOut};
   endfunction

   // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic drive(input logic c, input logic m, input logic p,
                        input logic [3:0] len, input logic [3:0] d);
      clear        = c;
      bus.mode     = m;
      bus.playEn   = p;
      bus.loop_len = len;
      bus.data     = d;
      model_step(c, m, p, len, d);
      @(posedge clock);
      #1;
   endtask

   task automatic go_playing();
      for (int i = 0; i < 4 && m_state != 0; i++) begin
         drive(1'b0, 1'b1, 1'b1, 4'd0, 4'b0);
         drive(1'b0, 1'b0, 1'b1, 4'd0, 4'b0);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_free_run();
      for (int k = 0; k < 40; k++) begin
         drive(1'b0, 1'b0, 1'b1, 4'd0, 4'b0);
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL free_run k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_record_play();
      logic       m;
      logic [3:0] d;
      for (int k = 0; k < 108; k++) begin
         m = (k == 0 || k == 41 || k == 43);
         d = 4'b0;
         if (k >= 1 && k <= 40 && m_phase == 1) begin
            if (m_ptr == 0) d = 4'b0001;
            else if (m_ptr == 2) d = 4'b1000;
         end
         drive(1'b0, m, 1'b1, 4'd0, d);
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL record_play k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_overdub();
      logic [3:0] d;
      for (int i = 0; i < TICK_DIV && m_phase != 0; i++) drive(1'b0, 1'b0, 1'b1, 4'd0, 4'b0);
      for (int k = 0; k < 72; k++) begin
         d = (k < 40 && m_ptr == 0 && m_phase == 1) ? 4'b0100 : 4'b0;
         drive(1'b0, (k == 0 || k == 2), 1'b0, 4'd0, d);
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL overdub k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_loop_len();
      logic [3:0] len;
      bit         shrunk;
      shrunk = 0;
      go_playing();
      for (int k = 0; k < 140; k++) begin
         if (k >= 24 && m_ptr == 2) shrunk = 1;
         if (k < 24) len = 4'd3;
         else if (k < 40) len = shrunk ? 4'd2 : 4'd3;
         else if (k < 90) len = 4'd0;
         else len = 4'd9;
         drive(1'b0, 1'b0, 1'b1, len, 4'($urandom));
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL loop_len k=%0d len=%0d {state,idx,pulse,seqOut} got %b want %b",
                     k, len, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_pause();
      go_playing();
      for (int k = 0; k < 40; k++) begin
         drive(1'b0, 1'b0, !(k >= 4 && k < 16), 4'd0, 4'b0);
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL pause k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_clear_mid();
      int         after;
      logic       c;
      logic [3:0] d;
      after = -1;
      go_playing();
      drive(1'b0, 1'b1, 1'b1, 4'd0, 4'b0);
      for (int k = 0; k < 200 && after < 40; k++) begin
         c = 1'b0;
         d = 4'b0;
         if (after < 0) begin
            d = (m_phase == 1) ? 4'b0010 : 4'b0;
            c = (k > 8 && m_ptr == 5 && m_phase == 2);
         end
         drive(c, 1'b0, 1'b1, 4'd0, d);
         if (c) after = 0;
         else if (after >= 0) after++;
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL clear_mid k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
      vectors++;
      if (after < 40) begin
         miscompares++;
         $display("FAIL clear_mid_reached got %0d replay cycles want 40", after);
      end
   endtask

   task automatic test_random();
      logic c;
      logic m;
      logic p;
      logic [3:0] len;
      logic [3:0] d;
      len = 4'd0;
      for (int k = 0; k < 500; k++) begin
         c = ($urandom_range(0, 199) == 0);
         m = ($urandom_range(0, 5) == 0);
         p = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) len = 4'($urandom);
         d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         drive(c, m, p, len, d);
         vectors++;
         if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random k=%0d {state,idx,pulse,seqOut} got %b want %b", k, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      clear        = 1'b1;
      bus.mode     = 1'b0;
      bus.playEn   = 1'b0;
      bus.loop_len = '0;
      bus.data     = '0;
      test_reset();
      test_free_run();
      test_record_play();
      test_overdub();
      test_loop_len();
      test_pause();
      test_clear_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
